// File: rtl/ofdm_pkg.sv
// Shared constants and types for the OFDM subcarrier framer: 64-bin map
// (nulls, pilots, data), bin classification enum and framer FSM states.
package ofdm_pkg;

    localparam int N_FFT   = 64;
    localparam int N_DATA  = 48;
    localparam int N_PILOT = 4;

    localparam logic [5:0] PILOT_0 = 6'd7;
    localparam logic [5:0] PILOT_1 = 6'd21;
    localparam logic [5:0] PILOT_2 = 6'd43;
    localparam logic [5:0] PILOT_3 = 6'd57;

    localparam logic [5:0] NULL_DC = 6'd0;
    localparam logic [5:0] NULL_LO = 6'd27;
    localparam logic [5:0] NULL_HI = 6'd37;

    localparam logic [5:0] LAST_WR  = 6'(N_DATA - 1);
    localparam logic [5:0] LAST_BIN = 6'(N_FFT - 1);

    typedef enum logic [1:0] {
        BIN_NULL,
        BIN_PILOT,
        BIN_DATA
    } bin_type_t;

    typedef enum logic {
        FILL,
        DRAIN
    } state_t;

endpackage

// File: rtl/ofdm_subcarrier_framer_classifier.sv
// Combinational bin classifier: maps a 6-bit bin index to its type and, for
// data bins, the ordinal of that data bin (frame buffer read address).
module ofdm_bin_classifier
    import ofdm_pkg::*;
(
    input  logic [5:0] bin_idx,
    output bin_type_t  bin_type,
    output logic [5:0] data_idx
);

    logic [5:0] skipped;

    always_comb begin
        bin_type = BIN_DATA;
        if (bin_idx == NULL_DC || (bin_idx >= NULL_LO && bin_idx <= NULL_HI))
            bin_type = BIN_NULL;
        else if (bin_idx == PILOT_0 || bin_idx == PILOT_1 ||
                 bin_idx == PILOT_2 || bin_idx == PILOT_3)
            bin_type = BIN_PILOT;

        // Data ordinal = bin index minus the non-data bins that precede it.
        skipped = 6'd1;
        if (bin_idx > PILOT_0) skipped = skipped + 6'd1;
        if (bin_idx > PILOT_1) skipped = skipped + 6'd1;
        if (bin_idx > NULL_HI) skipped = skipped + (NULL_HI - NULL_LO) + 6'd1;
        if (bin_idx > PILOT_2) skipped = skipped + 6'd1;
        if (bin_idx > PILOT_3) skipped = skipped + 6'd1;

        data_idx = (bin_type == BIN_DATA) ? bin_idx - skipped : 6'd0;
    end

endmodule

// File: rtl/ofdm_subcarrier_framer.sv
// OFDM subcarrier framer: buffers 48 data symbols, then emits a 64-bin frame
// with pilots and nulls. Optional macro OFDM_FRAMER_PILOT_TOGGLE_EN inverts pilots on odd frames.
module ofdm_subcarrier_framer
    import ofdm_pkg::*;
#(
    parameter int              DW      = 16,
    parameter logic [DW-1:0]   PILOT_I = 16'h001E,
    parameter logic [DW-1:0]   PILOT_Q = 16'h001E
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_i,
    input  logic [DW-1:0] in_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_i,
    output logic [DW-1:0] out_q,
    output logic [5:0]    out_idx,
    output logic          out_last
);

    state_t        state;
    logic [5:0]    wr_cnt;
    logic [5:0]    rd_idx;
    logic [5:0]    cls_idx;
    logic [5:0]    data_idx;
    bin_type_t     bin_type;
    logic [DW-1:0] buf_i [N_DATA];
    logic [DW-1:0] buf_q [N_DATA];
    logic [DW-1:0] pilot_i;
    logic [DW-1:0] pilot_q;
    logic [DW-1:0] nxt_i;
    logic [DW-1:0] nxt_q;
    logic          in_hs;
    logic          out_hs;

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    // Bin to be loaded into the output register on the next transfer.
    assign cls_idx = (state == DRAIN) ? rd_idx + 6'd1 : 6'd0;

    ofdm_bin_classifier u_classifier (
        .bin_idx  (cls_idx),
        .bin_type (bin_type),
        .data_idx (data_idx)
    );

`ifdef OFDM_FRAMER_PILOT_TOGGLE_EN
    logic parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            parity <= 1'b0;
        else if (out_hs && out_last)
            parity <= ~parity;
    end

    assign pilot_i = parity ? ~PILOT_I : PILOT_I;
    assign pilot_q = parity ? ~PILOT_Q : PILOT_Q;
`else
    assign pilot_i = PILOT_I;
    assign pilot_q = PILOT_Q;
`endif

    always_comb begin
        nxt_i = '0;
        nxt_q = '0;
        case (bin_type)
            BIN_PILOT: begin
                nxt_i = pilot_i;
                nxt_q = pilot_q;
            end
            BIN_DATA: begin
                nxt_i = buf_i[data_idx];
                nxt_q = buf_q[data_idx];
            end
            default: begin
                nxt_i = '0;
                nxt_q = '0;
            end
        endcase
    end

    // Frame buffer carries data only; it needs no reset.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            buf_i[wr_cnt] <= in_i;
            buf_q[wr_cnt] <= in_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            wr_cnt    <= '0;
            rd_idx    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_hs) begin
                        if (wr_cnt == LAST_WR) begin
                            wr_cnt    <= '0;
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            rd_idx    <= cls_idx;
                            out_i     <= nxt_i;
                            out_q     <= nxt_q;
                            out_idx   <= cls_idx;
                            out_last  <= (cls_idx == LAST_BIN);
                        end else begin
                            wr_cnt <= wr_cnt + 6'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        if (rd_idx == LAST_BIN) begin
                            state     <= FILL;
                            rd_idx    <= '0;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_i     <= '0;
                            out_q     <= '0;
                            out_idx   <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            rd_idx   <= cls_idx;
                            out_i    <= nxt_i;
                            out_q    <= nxt_q;
                            out_idx  <= cls_idx;
                            out_last <= (cls_idx == LAST_BIN);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_ofdm_subcarrier_framer.sv
// Self-checking bench for ofdm_subcarrier_framer: queue-based frame model,
// per-cycle compare on the falling edge, plus literal pins of the bin map.
module tb_ofdm_subcarrier_framer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_i;
    logic [15:0] in_q;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_i;
    logic [15:0] out_q;
    logic [5:0]  out_idx;
    logic        out_last;

    ofdm_subcarrier_framer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_i      (in_i),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic [5:0]  idx;
        logic        last;
    } bin_t;

    int          checks;
    int          failures;
    int          cyc;
    int          frames_out;
    int          model_parity;
    logic [15:0] acc_i [$];
    logic [15:0] acc_q [$];
    bin_t        expq [$];
    logic [15:0] cap_i [64];
    logic [15:0] cap_q [64];
    logic        cap_last [64];
    bit          mark_first;
    int          first_in_cyc;
    int          last_out_cyc;
    int          build_cyc;
    int          first_valid_cyc;
    logic        prev_valid;
    bit          rnd_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Lay the accumulated 48 symbols out over the 64-bin map.
    function automatic void build_frame();
        int   k;
        bin_t b;
        k = 0;
        for (int n = 0; n < 64; n++) begin
            b.idx  = 6'(n);
            b.last = (n == 63);
            if (n == 0 || (n >= 27 && n <= 37)) begin
                b.i = 16'h0;
                b.q = 16'h0;
            end else if (n == 7 || n == 21 || n == 43 || n == 57) begin
                b.i = 16'h001E;
                b.q = 16'h001E;
`ifdef OFDM_FRAMER_PILOT_TOGGLE_EN
                if (model_parity != 0) begin
                    b.i = ~b.i;
                    b.q = ~b.q;
                end
`endif
            end else begin
                b.i = acc_i[k];
                b.q = acc_q[k];
                k++;
            end
            expq.push_back(b);
        end
        acc_i.delete();
        acc_q.delete();
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            acc_i.delete();
            acc_q.delete();
            expq.delete();
            model_parity = 0;
            prev_valid = 1'b0;
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_out_i", {16'd0, out_i}, 32'd0);
            check("rst_out_q", {16'd0, out_q}, 32'd0);
            check("rst_out_idx", {26'd0, out_idx}, 32'd0);
            check("rst_out_last", {31'd0, out_last}, 32'd0);
        end else begin
            check("in_ready", {31'd0, in_ready}, {31'd0, expq.size() == 0});
            check("out_valid", {31'd0, out_valid}, {31'd0, expq.size() != 0});
            if (out_valid && !prev_valid) first_valid_cyc = cyc;
            prev_valid = out_valid;
            if (out_valid && expq.size() > 0) begin
                check("out_i", {16'd0, out_i}, {16'd0, expq[0].i});
                check("out_q", {16'd0, out_q}, {16'd0, expq[0].q});
                check("out_idx", {26'd0, out_idx}, {26'd0, expq[0].idx});
                check("out_last", {31'd0, out_last}, {31'd0, expq[0].last});
                if (out_ready) begin
                    cap_i[expq[0].idx]    = out_i;
                    cap_q[expq[0].idx]    = out_q;
                    cap_last[expq[0].idx] = out_last;
                    if (expq[0].last) begin
                        frames_out++;
                        last_out_cyc = cyc;
                        model_parity = 1 - model_parity;
                    end
                    void'(expq.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                if (!mark_first) begin
                    first_in_cyc = cyc;
                    mark_first = 1'b1;
                end
                acc_i.push_back(in_i);
                acc_q.push_back(in_q);
                if (acc_i.size() == 48) begin
                    build_cyc = cyc;
                    build_frame();
                end
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Offers symbols until nf frames have drained; pattern mode sends k / k+100.
    task automatic run(input int nf, input bit pattern, input bit gaps, input bit hold);
        int k;
        int t;
        int target;
        bit hs;
        bit want;
        k = 0;
        t = 0;
        target = frames_out + nf;
        while (frames_out < target && t < 5000) begin
            want = (k < 48 * nf) || hold;
            in_valid = want && (!gaps || $urandom_range(0, 3) != 0);
            in_i = pattern ? 16'(k) : 16'($urandom);
            in_q = pattern ? 16'(k + 100) : 16'($urandom);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs) k++;
            t++;
        end
        in_valid = 1'b0;
        if (t >= 5000) check("run_timeout", 32'(t), 32'd0);
    endtask

    task automatic send_n(input int n);
        int k;
        int t;
        bit hs;
        k = 0;
        t = 0;
        while (k < n && t < 1000) begin
            in_valid = 1'b1;
            in_i = 16'hD000 | 16'(k);
            in_q = 16'hE000 | 16'(k);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs) k++;
            t++;
        end
        in_valid = 1'b0;
        if (t >= 1000) check("send_timeout", 32'(t), 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        frames_out = 0;
        model_parity = 0;
        mark_first = 1'b0;
        prev_valid = 1'b0;
        rnd_ready = 1'b0;
        in_valid = 1'b0;
        in_i = '0;
        in_q = '0;
        rst_n = 1'b1;
        #2;
        do_reset();

        // Pattern frame with no stalls, pinned against literal bin values.
        run(1, 1'b1, 1'b0, 1'b0);
        check("bin0_i", {16'd0, cap_i[0]}, 32'h0);
        check("bin0_q", {16'd0, cap_q[0]}, 32'h0);
        check("bin1_i", {16'd0, cap_i[1]}, 32'd0);
        check("bin1_q", {16'd0, cap_q[1]}, 32'd100);
        check("bin7_i", {16'd0, cap_i[7]}, 32'h1E);
        check("bin7_q", {16'd0, cap_q[7]}, 32'h1E);
        check("bin8_i", {16'd0, cap_i[8]}, 32'd6);
        check("bin8_q", {16'd0, cap_q[8]}, 32'd106);
        check("bin30_q", {16'd0, cap_q[30]}, 32'h0);
        check("bin63_i", {16'd0, cap_i[63]}, 32'd47);
        check("bin63_q", {16'd0, cap_q[63]}, 32'd147);
        check("bin63_last", {31'd0, cap_last[63]}, 32'd1);
        check("bin62_last", {31'd0, cap_last[62]}, 32'd0);
        check("first_out_latency", 32'(first_valid_cyc - build_cyc), 32'd1);

        // Random data, random backpressure, in_valid held through the drain.
        rnd_ready = 1'b1;
        run(1, 1'b0, 1'b1, 1'b1);
        run(1, 1'b1, 1'b1, 1'b0);
        check("after_hold_bin1_q", {16'd0, cap_q[1]}, 32'd100);
        check("after_hold_bin6_i", {16'd0, cap_i[6]}, 32'd5);
        run(2, 1'b0, 1'b1, 1'b0);

        // Reset mid-fill: only the fresh symbols may appear.
        do_reset();
        send_n(20);
        do_reset();
        run(1, 1'b1, 1'b0, 1'b0);
        check("fresh_bin1_i", {16'd0, cap_i[1]}, 32'd0);
        check("fresh_bin63_i", {16'd0, cap_i[63]}, 32'd47);

        // Reset mid-drain.
        do_reset();
        send_n(48);
        repeat (5) @(posedge clk);
        #1;
        do_reset();

        // Two back-to-back frames with continuous input and no stalls.
        rnd_ready = 1'b0;
        do_reset();
        mark_first = 1'b0;
        run(2, 1'b0, 1'b0, 1'b1);
        check("two_frame_cycles", 32'(last_out_cyc - first_in_cyc + 1), 32'd224);
`ifdef OFDM_FRAMER_PILOT_TOGGLE_EN
        check("frame2_pilot_i", {16'd0, cap_i[21]}, 32'hFFE1);
        check("frame2_pilot_q", {16'd0, cap_q[57]}, 32'hFFE1);
`else
        check("frame2_pilot_i", {16'd0, cap_i[21]}, 32'h1E);
        check("frame2_pilot_q", {16'd0, cap_q[57]}, 32'h1E);
`endif
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
